gemm_skew_feed_ctrl: RTL
========================

// Module: gemm_skew_feed_ctrl
// PURPOSE
//  Sequences the bank of per-row skew shift chains that feed the GEMM systolic array.
//  Lane r of the bank is a data_shift_reg chain of depth r+1.
//  Accepts a job of K input vectors over a valid/ready stream and drives one common shift enable.
//  Zero-fills for ARRAY_DEPTH drain shifts, tracks per-lane validity of chain outputs, pulses done.
// PARAMETERS
//  ARRAY_DEPTH  32  number of lanes (rows); the deepest chain is ARRAY_DEPTH stages
//  CNT_W        16  width of job length k_len and the internal feed/drain counters
// PORTS
//  clk         in   1            clock; all state updates on posedge
//  reset       in   1            synchronous, active-high; one clock; reset is synchronous and active-high
//  start       in   1            job request; sampled only in IDLE
//  k_len       in   CNT_W        vectors in job; latched when start is accepted
//  abort       in   1            sync abort: return to IDLE, no done pulse
//  in_valid    in   1            upstream vector available
//  in_ready    out  1            controller accepts the vector this cycle
//  shift_en    out  1            common enable to every lane chain
//  zero_fill   out  1            1: bank input mux selects zero instead of upstream data
//  lane_valid  out  ARRAY_DEPTH  bit r=1: lane r chain output holds a real vector element
//  busy        out  1            state != IDLE
//  done        out  1            one-cycle pulse at job completion
// BEHAVIOUR
//  Reset (and abort):
//   - state=IDLE; counters=0; token reg tok=0.
//   - Outputs: in_ready=0, shift_en=0, zero_fill=0, lane_valid=0, busy=0, done=0.
//   - abort takes priority over every other event. Reset takes priority over abort.
//  FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE:
//   - IDLE:
//     - start & k_len!=0: latch k_len, feed_cnt=0, go to FEED.
//     - start & k_len==0: go to DONE directly; no shifts.
//   - FEED:
//     - in_ready=1; shift_en=in_valid (combinational); zero_fill=0.
//     - Each handshake does feed_cnt++.
//     - Handshake with feed_cnt==k_len-1: go to DRAIN, drain_cnt=0.
//     - in_valid=0: the whole bank stalls; tok holds.
//   - DRAIN:
//     - in_ready=0; shift_en=1; zero_fill=1 every cycle.
//     - drain_cnt++ each cycle.
//     - After ARRAY_DEPTH drain shifts, go to DONE. tok is all-zero at that point.
//   - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in FEED, DRAIN and DONE.
//  Start handling: start outside IDLE is ignored; k_len is not re-sampled mid-job.
//  Token tracking:
//   - On shift_en, tok <= {tok[ARRAY_DEPTH-2:0], ~zero_fill}; otherwise tok holds.
//   - lane_valid = tok (registered).
//   - Invariant: data entering on shift n appears on lane r after shift n+r.
//   - lane_valid[r] is 1 exactly while that element is at lane r's chain output.
//  Counters:
//   - Counters are CNT_W bits. k_len compares are unsigned.
//   - drain_cnt needs $clog2(ARRAY_DEPTH+1) <= CNT_W; a static check fails elaboration otherwise.
//  Reset or abort mid-FEED/DRAIN: tok cleared, so lane_valid drops next cycle.
//   - The data chains themselves are not cleared by this block.
//  Total shifts per job = k_len + ARRAY_DEPTH.
//   - Cycles from start to done = k_len + ARRAY_DEPTH + stall cycles + 1.
// TESTING
//  T1 D=4,K=3, in_valid=1:
//   - start@c0 -> in_ready c1-3, shift_en c1-7, zero_fill c4-7.
//   - lane_valid[0] c2-4, lane_valid[3] c5-7; done only @c8.
//  T2 D=4,K=3, in_valid low in c2 -> shift_en/in_ready handshake gap at c2.
//   - tok frozen at c2; done moves to c9.
//  T3 start with k_len=0 -> done @c1, shift_en never asserted, busy only c1.
//  T4 abort @c5 of T1 -> IDLE @c6, lane_valid=0 @c6, no done.
//   - New start @c6 runs normally.
//  T5 reset high @c3 of T1 -> all outputs at reset values @c4.
//   - start held in c2-7 during a job -> ignored; exactly one done.
//  T6 D=32,K=1000 random in_valid -> exactly 1000 handshakes and 1032 shifts.
//   - popcount(lane_valid)<=32 each cycle; scoreboard element order per lane.

Source files
------------

// File: rtl/gemm_skew_feed_ctrl_if.sv
// gemm_skew_feed_ctrl_if: job control, upstream handshake and shift-bank control bundle
interface gemm_skew_feed_ctrl_if #(
  parameter int ARRAY_DEPTH = 32,
  parameter int CNT_W = 16
);
  logic start;
  logic [CNT_W-1:0] k_len;
  logic abort;
  logic in_valid;
  logic in_ready;
  logic shift_en;
  logic zero_fill;
  logic [ARRAY_DEPTH-1:0] lane_valid;
  logic busy;
  logic done;
  modport master (
    output start, k_len, abort, in_valid,
    input in_ready, shift_en, zero_fill, lane_valid, busy, done
  );
  modport slave (
    input start, k_len, abort, in_valid,
    output in_ready, shift_en, zero_fill, lane_valid, busy, done
  );
endinterface

// File: rtl/gemm_skew_feed_ctrl.sv
// gemm_skew_feed_ctrl: sequences the skew shift-chain bank feeding the GEMM array
module gemm_skew_feed_ctrl #(
  parameter int ARRAY_DEPTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  gemm_skew_feed_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] k_reg, feed_cnt, drain_cnt;
  logic [ARRAY_DEPTH-1:0] tok;
  logic halt, hs, shift, zf;
  if ($clog2(ARRAY_DEPTH + 1) > CNT_W) begin : g_cnt_chk
    $error("CNT_W too narrow to count ARRAY_DEPTH drain shifts");
  end
  // A cycle that is being reset or aborted must not consume an upstream vector.
  assign halt = reset || bus.abort;
  assign hs = state == FEED && bus.in_valid && !halt;
  assign shift = !halt && (state == FEED ? bus.in_valid : state == DRAIN);
  assign zf = state == DRAIN;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (bus.start ? (bus.k_len == '0 ? DONE : FEED) : IDLE)
        : state == FEED  ? (hs && feed_cnt == k_reg - 1'b1 ? DRAIN : FEED)
        : state == DRAIN ? (drain_cnt == CNT_W'(ARRAY_DEPTH - 1) ? DONE : DRAIN)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset || bus.abort) begin
      state <= IDLE;
      k_reg <= '0;
      feed_cnt <= '0;
      drain_cnt <= '0;
      tok <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        k_reg <= bus.k_len;
        feed_cnt <= '0;
      end
      if (hs) feed_cnt <= feed_cnt + 1'b1;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      if (shift) tok <= {tok[ARRAY_DEPTH-2:0], ~zf};
    end
  end
  assign bus.in_ready = state == FEED && !halt;
  assign bus.shift_en = shift;
  assign bus.zero_fill = zf;
  assign bus.lane_valid = tok;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule
